// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source encodings and default datapath widths.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IN  = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous bus; output is DEPTH cycles old.
module sync_chain #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign o_q = stages[DEPTH-1];

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: register-file write port, OUT port register,
// synchronised IN port and retired-instruction counter.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic               i_write_back,
  input  logic [1:0]         i_wb_selector,
  input  logic [ADDR_W-1:0]  i_rd,
  input  logic [DATA_W-1:0]  i_alu_result,
  input  logic [DATA_W-1:0]  i_mem_data,
  input  logic [DATA_W-1:0]  i_imm,
  input  logic               i_output_port,
  input  logic [DATA_W-1:0]  i_data1,
  input  logic [DATA_W-1:0]  i_in_port,
  output logic               o_write_back,
  output logic [ADDR_W-1:0]  o_write_addr,
  output logic [DATA_W-1:0]  o_write_data,
  output logic [DATA_W-1:0]  o_out_port,
  output logic               o_out_strobe,
  output logic [COUNT_W-1:0] o_retired
);

  logic [DATA_W-1:0] in_sync;
  logic [DATA_W-1:0] wb_value;

  sync_chain #(
    .WIDTH (DATA_W),
    .DEPTH (SYNC_STAGES)
  ) u_in_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_in_port),
    .o_q     (in_sync)
  );

  always_comb begin
    wb_value = i_alu_result;
    case (wb_sel_e'(i_wb_selector))
      WB_ALU:  wb_value = i_alu_result;
      WB_MEM:  wb_value = i_mem_data;
      WB_IN:   wb_value = in_sync;
      WB_IMM:  wb_value = i_imm;
      default: wb_value = i_alu_result;
    endcase
  end

  // Flush outranks stall; the strobe drops on any non-loading edge so it
  // never stretches across a stall.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_write_back <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
      o_out_port   <= '0;
      o_out_strobe <= 1'b0;
      o_retired    <= '0;
    end else if (i_flush) begin
      o_write_back <= 1'b0;
      o_out_strobe <= 1'b0;
    end else if (i_stall) begin
      o_out_strobe <= 1'b0;
    end else begin
      o_write_back <= i_valid & i_write_back;
      o_write_addr <= i_rd;
      o_write_data <= wb_value;
      o_out_strobe <= i_valid & i_output_port;
      if (i_valid & i_output_port) o_out_port <= i_data1;
      if (i_valid) o_retired <= o_retired + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_writeback_stage;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, flush = 1'b0, valid = 1'b0, wbk = 1'b0, outp = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] alu = '0, mem = '0, imm = '0, data1 = '0, in_port = '0;

  logic          o_we, o_strobe;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data, o_out;
  logic [CW-1:0] o_ret;

  int n_cmp = 0;
  int n_fail = 0;

  writeback_stage #(
    .DATA_W (DW), .ADDR_W (AW), .COUNT_W (CW), .SYNC_STAGES (SS)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_valid       (valid),
    .i_write_back  (wbk),
    .i_wb_selector (sel),
    .i_rd          (rd),
    .i_alu_result  (alu),
    .i_mem_data    (mem),
    .i_imm         (imm),
    .i_output_port (outp),
    .i_data1       (data1),
    .i_in_port     (in_port),
    .o_write_back  (o_we),
    .o_write_addr  (o_addr),
    .o_write_data  (o_data),
    .o_out_port    (o_out),
    .o_out_strobe  (o_strobe),
    .o_retired     (o_ret)
  );

  always #5 clk = ~clk;

  // Reference model: what the write port must show after each edge.
  logic          m_we = 1'b0, m_strobe = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0, m_out = '0, m_in_val = '0;
  int            m_ret = 0;
  logic [DW-1:0] in_q [$] = '{16'h0, 16'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we = 1'b0; m_strobe = 1'b0; m_addr = '0; m_data = '0; m_out = '0; m_ret = 0;
      in_q = {};
      repeat (SS) in_q.push_back('0);
    end else begin
      m_in_val = in_q.pop_front();
      in_q.push_back(in_port);
      if (flush) begin
        m_we = 1'b0;
        m_strobe = 1'b0;
      end else if (stall) begin
        m_strobe = 1'b0;
      end else begin
        m_we   = valid && wbk;
        m_addr = rd;
        case (sel)
          2'd0: m_data = alu;
          2'd1: m_data = mem;
          2'd2: m_data = m_in_val;
          default: m_data = imm;
        endcase
        m_strobe = valid && outp;
        if (valid && outp) m_out = data1;
        if (valid) m_ret = (m_ret + 1) % (1 << CW);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model_we", DW'(o_we), DW'(m_we));
    if (m_we) begin
      checkOutput("model_addr", DW'(o_addr), DW'(m_addr));
      checkOutput("model_data", o_data, m_data);
    end
    checkOutput("model_out", o_out, m_out);
    checkOutput("model_strobe", DW'(o_strobe), DW'(m_strobe));
    checkOutput("model_retired", DW'(o_ret), DW'(m_ret));
  end

  task automatic applyStimulus(input logic v, input logic w, input logic [1:0] s,
                               input logic [AW-1:0] r, input logic [DW-1:0] a,
                               input logic op, input logic [DW-1:0] d1,
                               input logic st, input logic fl);
    valid = v; wbk = w; sel = s; rd = r; alu = a;
    outp = op; data1 = d1; stall = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    mem = 16'hBEEF;
    imm = 16'h00FF;
    in_port = 16'hA5A5;
    repeat (2) @(negedge clk);
    checkOutput("reset_we", DW'(o_we), 16'h0);
    checkOutput("reset_retired", DW'(o_ret), 16'h0);
    rst = 1'b0;

    applyStimulus(1, 1, 2'd0, 3'd5, 16'h1234, 0, 16'h0, 0, 0);
    checkOutput("alu_we", DW'(o_we), 16'h1);
    checkOutput("alu_addr", DW'(o_addr), 16'h5);
    checkOutput("alu_data", o_data, 16'h1234);
    checkOutput("alu_retired", DW'(o_ret), 16'h1);

    applyStimulus(1, 1, 2'd0, 3'd1, 16'h1111, 0, 16'h0, 0, 0);
    checkOutput("sel_alu", o_data, 16'h1111);
    applyStimulus(1, 1, 2'd1, 3'd2, 16'h2222, 0, 16'h0, 0, 0);
    checkOutput("sel_mem", o_data, 16'hBEEF);
    applyStimulus(1, 1, 2'd3, 3'd3, 16'h3333, 0, 16'h0, 0, 0);
    checkOutput("sel_imm", o_data, 16'h00FF);
    applyStimulus(1, 1, 2'd2, 3'd4, 16'h4444, 0, 16'h0, 0, 0);
    checkOutput("sel_in", o_data, 16'hA5A5);
    checkOutput("sel_retired", DW'(o_ret), 16'h5);

    applyStimulus(1, 1, 2'd0, 3'd2, 16'h0042, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 2'd1, 3'd7, 16'h7000 + 16'(i), 1, 16'h0, 1, 0);
      checkOutput("stall_addr", DW'(o_addr), 16'h2);
      checkOutput("stall_data", o_data, 16'h0042);
      checkOutput("stall_we", DW'(o_we), 16'h1);
      checkOutput("stall_retired", DW'(o_ret), 16'h6);
    end
    applyStimulus(1, 1, 2'd0, 3'd6, 16'h0666, 0, 16'h0, 1, 1);
    checkOutput("flush_we", DW'(o_we), 16'h0);
    checkOutput("flush_retired", DW'(o_ret), 16'h6);

    applyStimulus(1, 0, 2'd0, 3'd0, 16'h0, 1, 16'h55AA, 0, 0);
    checkOutput("out_port", o_out, 16'h55AA);
    checkOutput("out_strobe", DW'(o_strobe), 16'h1);
    checkOutput("out_we", DW'(o_we), 16'h0);
    applyStimulus(0, 0, 2'd0, 3'd0, 16'h0, 0, 16'h9999, 0, 0);
    checkOutput("bubble_strobe", DW'(o_strobe), 16'h0);
    checkOutput("bubble_out", o_out, 16'h55AA);
    checkOutput("bubble_retired", DW'(o_ret), 16'h7);

    applyStimulus(1, 1, 2'd3, 3'd1, 16'h0, 1, 16'h1357, 0, 0);
    checkOutput("outwb_we", DW'(o_we), 16'h1);
    checkOutput("outwb_data", o_data, 16'h00FF);
    checkOutput("outwb_out", o_out, 16'h1357);
    checkOutput("outwb_strobe", DW'(o_strobe), 16'h1);
    applyStimulus(1, 0, 2'd0, 3'd0, 16'h0, 1, 16'h2468, 1, 0);
    checkOutput("stall_strobe", DW'(o_strobe), 16'h0);
    checkOutput("stall_out", o_out, 16'h1357);
    checkOutput("stall_ret8", DW'(o_ret), 16'h8);

    // Asynchronous reset between edges, with traffic still on the inputs.
    applyStimulus(1, 1, 2'd0, 3'd3, 16'hABCD, 1, 16'h1111, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_we", DW'(o_we), 16'h0);
    checkOutput("arst_addr", DW'(o_addr), 16'h0);
    checkOutput("arst_data", o_data, 16'h0);
    checkOutput("arst_out", o_out, 16'h0);
    checkOutput("arst_strobe", DW'(o_strobe), 16'h0);
    checkOutput("arst_retired", DW'(o_ret), 16'h0);
    applyStimulus(0, 0, 2'd0, 3'd0, 16'h0, 0, 16'h0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, (i % 3) != 0, 2'(i), 3'(i), 16'h0100 + 16'(i), 0, 16'h0, 0, 0);
      if ((i % 4) == 3) applyStimulus(0, 1, 2'd0, 3'd0, 16'hDEAD, 1, 16'hDEAD, 0, 0);
    end
    checkOutput("wrap_retired", DW'(o_ret), 16'h1);

    applyStimulus(0, 0, 2'd0, 3'd0, 16'h0, 0, 16'h0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
